tcp_conn_demux: RTL and testbench

TCP_CONN_DEMUX -- requirements
Module: tcp_conn_demux

---
 rtl/tcp_conn_demux_pkg.sv | 35 +++
 rtl/tcp_conn_demux_if.sv | 44 ++++
 rtl/tcp_conn_match.sv | 30 +++
 rtl/tcp_conn_demux.sv | 140 ++++++++++++++
 tb/tb_tcp_conn_demux.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_conn_demux_pkg.sv
// Shared TCP/IPv4 constants and connection-table types for the TCP connection demultiplexer.
package tcp_conn_demux_pkg;

  localparam int unsigned TCP_PORT_W  = 16;
  localparam int unsigned IPV4_ADDR_W = 32;
  localparam int unsigned SEG_LEN_W   = 16;

  typedef struct packed {
    logic                   en;
    logic [IPV4_ADDR_W-1:0] src_ip;
    logic [TCP_PORT_W-1:0]  src_port;
    logic [TCP_PORT_W-1:0]  dst_port;
  } conn_entry_t;

  typedef struct packed {
    logic [IPV4_ADDR_W-1:0] src_ip;
    logic [TCP_PORT_W-1:0]  src_port;
    logic [TCP_PORT_W-1:0]  dst_port;
    logic [SEG_LEN_W-1:0]   payload_len;
  } seg_meta_t;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLookup = 2'd1;
  localparam logic [1:0] StFwd    = 2'd2;
  localparam logic [1:0] StDrop   = 2'd3;

  function automatic logic entry_matches(input conn_entry_t            e,
                                         input logic [IPV4_ADDR_W-1:0] src_ip,
                                         input logic [TCP_PORT_W-1:0]  src_port,
                                         input logic [TCP_PORT_W-1:0]  dst_port);
    return e.en && (e.src_ip == src_ip) && (e.src_port == src_port) &&
           (e.dst_port == dst_port);
  endfunction

endpackage

// File: rtl/tcp_conn_demux_if.sv
// Stream-side bundle of the TCP connection demultiplexer: segment metadata, upstream payload
// and the per-connection output channels.
interface tcp_conn_demux_if #(
  parameter int unsigned NUM_CONN = 4,
  parameter int unsigned DATA_W   = 8
);
  import tcp_conn_demux_pkg::*;

  logic                   meta_valid;
  logic                   meta_ready;
  logic [IPV4_ADDR_W-1:0] meta_src_ip;
  logic [TCP_PORT_W-1:0]  meta_src_port;
  logic [TCP_PORT_W-1:0]  meta_dst_port;
  logic [SEG_LEN_W-1:0]   meta_payload_len;

  logic [DATA_W-1:0]          s_axis_tdata;
  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic                       s_axis_tlast;

  logic [NUM_CONN*DATA_W-1:0] m_axis_tdata;
  logic [NUM_CONN-1:0]        m_axis_tvalid;
  logic [NUM_CONN-1:0]        m_axis_tready;
  logic [NUM_CONN-1:0]        m_axis_tlast;

  modport master (
    output meta_valid, meta_src_ip, meta_src_port, meta_dst_port, meta_payload_len,
    input  meta_ready,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

  modport slave (
    input  meta_valid, meta_src_ip, meta_src_port, meta_dst_port, meta_payload_len,
    output meta_ready,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

endinterface

// File: rtl/tcp_conn_match.sv
// Connection-table compare: flags every enabled slot whose 3-tuple equals the key and
// reports the lowest-numbered match.
module tcp_conn_match
  import tcp_conn_demux_pkg::*;
#(
  parameter int unsigned NUM_CONN = 4
) (
  input  conn_entry_t [NUM_CONN-1:0]      entries,
  input  logic [IPV4_ADDR_W-1:0]          key_src_ip,
  input  logic [TCP_PORT_W-1:0]           key_src_port,
  input  logic [TCP_PORT_W-1:0]           key_dst_port,
  output logic                            hit,
  output logic [$clog2(NUM_CONN)-1:0]     idx
);

  localparam int unsigned IDX_W = $clog2(NUM_CONN);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Walk downwards so the lowest matching slot is the last one to win.
    for (int i = int'(NUM_CONN) - 1; i >= 0; i--) begin
      if (entry_matches(entries[i], key_src_ip, key_src_port, key_dst_port)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tcp_conn_demux.sv
// Steers each TCP segment payload to the output channel of its matching connection slot,
// or sinks it when no slot matches.
module tcp_conn_demux
  import tcp_conn_demux_pkg::*;
#(
  parameter int unsigned NUM_CONN = 4,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,

  input  logic                            cfg_wr,
  input  logic [$clog2(NUM_CONN)-1:0]     cfg_idx,
  input  logic                            cfg_en,
  input  logic [IPV4_ADDR_W-1:0]          cfg_src_ip,
  input  logic [TCP_PORT_W-1:0]           cfg_src_port,
  input  logic [TCP_PORT_W-1:0]           cfg_dst_port,

  tcp_conn_demux_if.slave                 bus,

  output logic                            hit_pulse,
  output logic [$clog2(NUM_CONN)-1:0]     hit_idx,
  output logic                            miss_pulse,
  output logic [15:0]                     miss_count
);

  localparam int unsigned IDX_W = $clog2(NUM_CONN);

  logic [1:0]                 state_q, state_d;
  logic                       run_q;
  seg_meta_t                  meta_q;
  logic [IDX_W-1:0]           sel_q;
  conn_entry_t [NUM_CONN-1:0] tbl_q;
  logic                       hit_pulse_q, miss_pulse_q;
  logic [IDX_W-1:0]           hit_idx_q;
  logic [15:0]                miss_count_q, miss_count_d;

  logic                       match_hit;
  logic [IDX_W-1:0]           match_idx;
  logic                       meta_accept, in_lookup, beat_last;

  tcp_conn_match #(
    .NUM_CONN (NUM_CONN)
  ) u_match (
    .entries      (tbl_q),
    .key_src_ip   (meta_q.src_ip),
    .key_src_port (meta_q.src_port),
    .key_dst_port (meta_q.dst_port),
    .hit          (match_hit),
    .idx          (match_idx)
  );

  // run_q keeps meta_ready low until the first clock after reset release.
  assign bus.meta_ready = run_q && (state_q == StIdle);
  assign meta_accept    = bus.meta_valid && bus.meta_ready;
  assign in_lookup      = (state_q == StLookup);
  assign beat_last      = bus.s_axis_tvalid && bus.s_axis_tready && bus.s_axis_tlast;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (meta_accept) state_d = StLookup;
      StLookup: begin
        if (meta_q.payload_len == '0) state_d = StIdle;
        else if (match_hit)           state_d = StFwd;
        else                          state_d = StDrop;
      end
      StFwd:    if (beat_last) state_d = StIdle;
      StDrop:   if (beat_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    miss_count_d = miss_count_q;
    if (in_lookup && !match_hit && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_comb begin
    bus.s_axis_tready = 1'b0;
    bus.m_axis_tdata  = '0;
    bus.m_axis_tvalid = '0;
    bus.m_axis_tlast  = '0;
    if (state_q == StDrop) begin
      bus.s_axis_tready = 1'b1;
    end else if (state_q == StFwd) begin
      bus.s_axis_tready = bus.m_axis_tready[sel_q];
      for (int i = 0; i < int'(NUM_CONN); i++) begin
        if (sel_q == IDX_W'(i)) begin
          bus.m_axis_tdata[i*DATA_W +: DATA_W] = bus.s_axis_tdata;
          bus.m_axis_tvalid[i]                 = bus.s_axis_tvalid;
          bus.m_axis_tlast[i]                  = bus.s_axis_tlast;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      run_q        <= 1'b0;
      meta_q       <= '0;
      sel_q        <= '0;
      tbl_q        <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      hit_idx_q    <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      miss_count_q <= miss_count_d;
      hit_pulse_q  <= in_lookup && match_hit;
      miss_pulse_q <= in_lookup && !match_hit;
      if (meta_accept) begin
        meta_q <= '{src_ip:      bus.meta_src_ip,
                    src_port:    bus.meta_src_port,
                    dst_port:    bus.meta_dst_port,
                    payload_len: bus.meta_payload_len};
      end
      // sel_q only moves in LOOKUP, so table writes during FWD cannot redirect the segment.
      if (in_lookup) sel_q <= match_idx;
      if (in_lookup && match_hit) hit_idx_q <= match_idx;
      if (cfg_wr && (32'(cfg_idx) < NUM_CONN)) begin
        tbl_q[cfg_idx] <= '{en:       cfg_en,
                            src_ip:   cfg_src_ip,
                            src_port: cfg_src_port,
                            dst_port: cfg_dst_port};
      end
    end
  end

  assign hit_pulse  = hit_pulse_q;
  assign hit_idx    = hit_idx_q;
  assign miss_pulse = miss_pulse_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_tcp_conn_demux.sv
// Randomised self-checking bench for tcp_conn_demux against a tuple-table reference model.
module tb_tcp_conn_demux;
  import tcp_conn_demux_pkg::*;

  localparam int unsigned NC = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_wr;
  logic [IW-1:0] cfg_idx;
  logic          cfg_en;
  logic [31:0]   cfg_src_ip;
  logic [15:0]   cfg_src_port, cfg_dst_port;
  logic          hit_pulse, miss_pulse;
  logic [IW-1:0] hit_idx;
  logic [15:0]   miss_count;

  tcp_conn_demux_if #(.NUM_CONN(NC), .DATA_W(DW)) bus ();

  tcp_conn_demux #(.NUM_CONN(NC), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr       (cfg_wr),
    .cfg_idx      (cfg_idx),
    .cfg_en       (cfg_en),
    .cfg_src_ip   (cfg_src_ip),
    .cfg_src_port (cfg_src_port),
    .cfg_dst_port (cfg_dst_port),
    .bus          (bus),
    .hit_pulse    (hit_pulse),
    .hit_idx      (hit_idx),
    .miss_pulse   (miss_pulse),
    .miss_count   (miss_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the connection table as the spec describes it, plus the miss tally.
  conn_entry_t mtbl [NC];
  int          m_miss = 0;

  function automatic int model_lookup(input logic [31:0] ip, input logic [15:0] sp,
                                      input logic [15:0] dp);
    for (int i = 0; i < int'(NC); i++) begin
      if (mtbl[i].en && mtbl[i].src_ip == ip && mtbl[i].src_port == sp &&
          mtbl[i].dst_port == dp) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(NC); i++) mtbl[i].en = 1'b0;
    m_miss = 0;
  endfunction

  task automatic init_inputs();
    cfg_wr = 0; cfg_idx = '0; cfg_en = 0; cfg_src_ip = '0; cfg_src_port = '0;
    cfg_dst_port = '0;
    bus.meta_valid = 0; bus.meta_src_ip = '0; bus.meta_src_port = '0;
    bus.meta_dst_port = '0; bus.meta_payload_len = '0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0;
    bus.m_axis_tready = '1;
  endtask

  task automatic cfg_write(input int idx, input logic en, input logic [31:0] ip,
                           input logic [15:0] sp, input logic [15:0] dp);
    @(negedge clk);
    cfg_wr = 1; cfg_idx = IW'(idx); cfg_en = en; cfg_src_ip = ip; cfg_src_port = sp;
    cfg_dst_port = dp;
    @(negedge clk);
    cfg_wr = 0;
    mtbl[idx] = '{en: en, src_ip: ip, src_port: sp, dst_port: dp};
  endtask

  // One segment end to end. rdy_mode: 0 all ready, 1 toggling, 2 random.
  // lk_wr disables ev_slot during LOOKUP; dis_at disables it when byte dis_at is offered;
  // rst_at asserts reset when byte rst_at is offered.
  task automatic run_segment(input logic [31:0] ip, input logic [15:0] sp,
                             input logic [15:0] dp, input int len, input int rdy_mode,
                             input bit vld_rand, input int ev_slot, input bit lk_wr,
                             input int dis_at, input int rst_at);
    logic [7:0]         sent[$];
    logic [7:0]         got[$];
    int                 got_ch[$];
    int                 exp_ch, k, budget;
    logic               tog, exp_rdy;
    logic [NC-1:0]      exp_v, exp_l;
    logic [NC*DW-1:0]   exp_d;
    for (int i = 0; i < len; i++) sent.push_back(8'($urandom));
    exp_ch = model_lookup(ip, sp, dp);

    @(negedge clk);
    bus.meta_valid = 1; bus.meta_src_ip = ip; bus.meta_src_port = sp;
    bus.meta_dst_port = dp; bus.meta_payload_len = 16'(len);
    #1;
    n_checks++;
    if (bus.meta_ready !== 1'b1) begin
      n_errors++; $display("FAIL meta_ready_idle: got %b expected 1", bus.meta_ready);
    end

    @(negedge clk);
    bus.meta_valid = 0;
    if (lk_wr) begin
      cfg_wr = 1; cfg_idx = IW'(ev_slot); cfg_en = 0; cfg_src_ip = ip;
      cfg_src_port = sp; cfg_dst_port = dp;
    end
    #1;
    n_checks++;
    if ({bus.meta_ready, bus.s_axis_tready, bus.m_axis_tvalid} !== '0) begin
      n_errors++;
      $display("FAIL lookup_quiet: got meta_ready=%b s_tready=%b m_tvalid=%b expected all 0",
               bus.meta_ready, bus.s_axis_tready, bus.m_axis_tvalid);
    end

    @(negedge clk);
    cfg_wr = 0;
    if (lk_wr) mtbl[ev_slot].en = 1'b0;
    if (exp_ch < 0) m_miss = (m_miss >= 65535) ? 65535 : m_miss + 1;
    n_checks++;
    if (hit_pulse !== (exp_ch >= 0) || miss_pulse !== (exp_ch < 0)) begin
      n_errors++;
      $display("FAIL pulses: got hit=%b miss=%b expected hit=%b miss=%b", hit_pulse,
               miss_pulse, exp_ch >= 0, exp_ch < 0);
    end
    if (exp_ch >= 0) begin
      n_checks++;
      if (hit_idx !== IW'(exp_ch)) begin
        n_errors++; $display("FAIL hit_idx: got %0d expected %0d", hit_idx, exp_ch);
      end
    end
    n_checks++;
    if (miss_count !== 16'(m_miss)) begin
      n_errors++; $display("FAIL miss_count: got %0d expected %0d", miss_count, m_miss);
    end

    k = 0; budget = 0; tog = 1'b1;
    while (k < len && budget < 200) begin
      if (budget > 0) begin
        @(negedge clk);
        cfg_wr = 0;
      end
      budget++;
      bus.s_axis_tvalid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.s_axis_tdata  = sent[k];
      bus.s_axis_tlast  = (k == len - 1);
      case (rdy_mode)
        0:       bus.m_axis_tready = '1;
        1:       begin bus.m_axis_tready = {NC{tog}}; tog = ~tog; end
        default: bus.m_axis_tready = NC'($urandom);
      endcase
      if (k == dis_at && bus.s_axis_tvalid) begin
        cfg_wr = 1; cfg_idx = IW'(ev_slot); cfg_en = 0; cfg_src_ip = ip;
        cfg_src_port = sp; cfg_dst_port = dp;
        mtbl[ev_slot].en = 1'b0;
        dis_at = -1;
      end
      if (k == rst_at) begin
        bus.s_axis_tvalid = 1;
        rst_n = 0;
        #1;
        model_reset();
        n_checks++;
        if ({bus.m_axis_tvalid, bus.s_axis_tready, bus.meta_ready} !== '0) begin
          n_errors++;
          $display("FAIL reset_outputs: got m_tvalid=%b s_tready=%b meta_ready=%b expected 0",
                   bus.m_axis_tvalid, bus.s_axis_tready, bus.meta_ready);
        end
        n_checks++;
        if ({hit_pulse, miss_pulse, hit_idx, miss_count} !== '0) begin
          n_errors++;
          $display("FAIL reset_status: got hit=%b miss=%b idx=%0d cnt=%0d expected 0",
                   hit_pulse, miss_pulse, hit_idx, miss_count);
        end
        return;
      end
      #1;
      exp_rdy = (exp_ch >= 0) ? bus.m_axis_tready[exp_ch] : 1'b1;
      exp_v = '0; exp_l = '0; exp_d = '0;
      if (exp_ch >= 0) begin
        exp_v[exp_ch] = bus.s_axis_tvalid;
        exp_l[exp_ch] = bus.s_axis_tlast;
        exp_d[exp_ch*DW +: DW] = sent[k];
      end
      n_checks++;
      if (bus.s_axis_tready !== exp_rdy) begin
        n_errors++; $display("FAIL s_tready: got %b expected %b", bus.s_axis_tready, exp_rdy);
      end
      n_checks++;
      if (bus.m_axis_tvalid !== exp_v) begin
        n_errors++; $display("FAIL m_tvalid: got %b expected %b", bus.m_axis_tvalid, exp_v);
      end
      n_checks++;
      if (bus.m_axis_tdata !== exp_d) begin
        n_errors++; $display("FAIL m_tdata: got %h expected %h", bus.m_axis_tdata, exp_d);
      end
      n_checks++;
      if (bus.m_axis_tlast !== exp_l) begin
        n_errors++; $display("FAIL m_tlast: got %b expected %b", bus.m_axis_tlast, exp_l);
      end
      for (int j = 0; j < int'(NC); j++) begin
        if (bus.m_axis_tvalid[j] && bus.m_axis_tready[j]) begin
          got.push_back(bus.m_axis_tdata[j*DW +: DW]);
          got_ch.push_back(j);
        end
      end
      if (bus.s_axis_tvalid && bus.s_axis_tready) k++;
    end

    n_checks++;
    if (k != len) begin
      n_errors++; $display("FAIL stream_timeout: got %0d bytes accepted expected %0d", k, len);
    end
    n_checks++;
    if (got.size() != ((exp_ch >= 0) ? len : 0)) begin
      n_errors++;
      $display("FAIL delivered_count: got %0d expected %0d", got.size(),
               (exp_ch >= 0) ? len : 0);
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        n_checks++;
        if (got[i] !== sent[i] || got_ch[i] != exp_ch) begin
          n_errors++;
          $display("FAIL delivered_byte[%0d]: got %h on ch%0d expected %h on ch%0d", i,
                   got[i], got_ch[i], sent[i], exp_ch);
        end
      end
    end

    @(negedge clk);
    bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; cfg_wr = 0;
    #1;
    n_checks++;
    if (bus.meta_ready !== 1'b1 || bus.m_axis_tvalid !== '0) begin
      n_errors++;
      $display("FAIL back_to_idle: got meta_ready=%b m_tvalid=%b expected 1 and 0",
               bus.meta_ready, bus.m_axis_tvalid);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1;
    init_inputs();
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.meta_ready !== 1'b1 || bus.s_axis_tready !== 1'b0) begin
      n_errors++;
      $display("FAIL after_reset: got meta_ready=%b s_tready=%b expected 1 and 0",
               bus.meta_ready, bus.s_axis_tready);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if ({bus.meta_ready, bus.s_axis_tready, bus.m_axis_tvalid} !== '0) begin
      n_errors++;
      $display("FAIL in_reset_outputs: got meta_ready=%b s_tready=%b m_tvalid=%b expected 0",
               bus.meta_ready, bus.s_axis_tready, bus.m_axis_tvalid);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({hit_pulse, miss_pulse, hit_idx, miss_count, bus.meta_ready} !== '0) begin
      n_errors++;
      $display("FAIL in_reset_status: got hit=%b miss=%b idx=%0d cnt=%0d meta_ready=%b",
               hit_pulse, miss_pulse, hit_idx, miss_count, bus.meta_ready);
    end
    release_reset();
  endtask

  task automatic test_hit_basic();
    cfg_write(2, 1, 32'h0A000005, 16'd5000, 16'd80);
    run_segment(32'h0A000005, 16'd5000, 16'd80, 4, 0, 0, 0, 0, -1, -1);
  endtask

  task automatic test_miss();
    run_segment(32'h0A000006, 16'd5000, 16'd80, 6, 2, 1, 0, 0, -1, -1);
    n_checks++;
    if (miss_count !== 16'd1) begin
      n_errors++; $display("FAIL first_miss_count: got %0d expected 1", miss_count);
    end
  endtask

  task automatic test_priority();
    cfg_write(1, 1, 32'hC0A80101, 16'd1234, 16'd443);
    cfg_write(3, 1, 32'hC0A80101, 16'd1234, 16'd443);
    run_segment(32'hC0A80101, 16'd1234, 16'd443, 5, 2, 1, 0, 0, -1, -1);
  endtask

  task automatic test_backpressure();
    cfg_write(0, 1, 32'h0A000001, 16'd7000, 16'd22);
    run_segment(32'h0A000001, 16'd7000, 16'd22, 8, 1, 0, 0, 0, -1, -1);
  endtask

  task automatic test_cfg_during_lookup();
    cfg_write(0, 1, 32'h0A000002, 16'd7001, 16'd22);
    run_segment(32'h0A000002, 16'd7001, 16'd22, 3, 0, 0, 0, 1, -1, -1);
    run_segment(32'h0A000002, 16'd7001, 16'd22, 2, 0, 0, 0, 0, -1, -1);
  endtask

  task automatic test_disable_mid_fwd();
    cfg_write(0, 1, 32'h0A000003, 16'd7002, 16'd25);
    run_segment(32'h0A000003, 16'd7002, 16'd25, 6, 0, 0, 0, 0, 2, -1);
    run_segment(32'h0A000003, 16'd7002, 16'd25, 2, 0, 0, 0, 0, -1, -1);
  endtask

  task automatic test_zero_len();
    run_segment(32'h0A000005, 16'd5000, 16'd80, 0, 0, 0, 0, 0, -1, -1);
    run_segment(32'h0B000005, 16'd5000, 16'd80, 0, 0, 0, 0, 0, -1, -1);
  endtask

  task automatic test_random();
    for (int s = 0; s < int'(NC); s++) begin
      cfg_write(s, 1'($urandom_range(0, 1)), 32'h0A000010 + 32'($urandom_range(0, 1)),
                16'd1000 + 16'($urandom_range(0, 1)), 16'd80);
    end
    repeat (16) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_write($urandom_range(0, NC - 1), 1'($urandom_range(0, 1)),
                  32'h0A000010 + 32'($urandom_range(0, 1)),
                  16'd1000 + 16'($urandom_range(0, 1)), 16'd80);
      end
      run_segment(32'h0A000010 + 32'($urandom_range(0, 1)),
                  16'd1000 + 16'($urandom_range(0, 1)), 16'd80, $urandom_range(0, 10),
                  2, 1, 0, 0, -1, -1);
    end
  endtask

  task automatic test_reset_mid_fwd();
    cfg_write(1, 1, 32'h0A0000AA, 16'd9000, 16'd8080);
    run_segment(32'h0A0000AA, 16'd9000, 16'd8080, 6, 0, 0, 0, 0, -1, 2);
    release_reset();
    run_segment(32'h0A0000AA, 16'd9000, 16'd8080, 1, 0, 0, 0, 0, -1, -1);
  endtask

  // Preload the counter near its ceiling rather than spend 128k cycles on real misses.
  task automatic test_miss_saturation();
    @(negedge clk);
    force dut.miss_count_q = 16'hFFFD;
    @(posedge clk);
    #1 release dut.miss_count_q;
    m_miss = 65533;
    for (int i = 0; i < 4; i++) begin
      run_segment(32'hDEAD0001, 16'd1, 16'd2, (i == 1) ? 3 : 0, 0, 0, 0, 0, -1, -1);
    end
    n_checks++;
    if (miss_count !== 16'hFFFF) begin
      n_errors++; $display("FAIL miss_saturate: got %h expected ffff", miss_count);
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_hit_basic();
    test_miss();
    test_priority();
    test_backpressure();
    test_cfg_during_lookup();
    test_disable_mid_fwd();
    test_zero_len();
    test_random();
    test_reset_mid_fwd();
    test_miss_saturation();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
